seq_mult_param: RTL and testbench
=================================

// Module: seq_mult_param
// PURPOSE
//  Parametrised multi-cycle shift/add multiplier. Successor to the fixed 32-bit
//  signed sequential multiplier. Adds width and radix parameters, per-operation
//  signed/unsigned mode, operand capture at start, and a ready/valid handshake.
//  Sits beside the datapath ALU as its long-latency multiply unit.
// PARAMETERS
//  WIDTH    32  operand width in bits; even, >= 4
//  BPC      1   multiplier bits retired per cycle: 1 (radix-2) or 2 (radix-4, two partial adds/cycle)
// PORTS
//  clock    in   1        rising-edge clock
//  reset_n  in   1        asynchronous, active-low reset
//  start    in   1        request; accepted only on an edge where ready=1
//  sgn      in   1        1 = two's-complement operands, 0 = unsigned; captured at accept
//  mlier    in   WIDTH    multiplier; captured at accept
//  mcand    in   WIDTH    multiplicand; captured at accept
//  ready    out  1        1 in IDLE and DONE (can accept)
//  valid    out  1        1 in DONE: prodt holds a finished result
//  prodt    out  2*WIDTH  product register
// BEHAVIOUR
//  Reset (reset_n=0, any time incl. mid-operation): state=IDLE, ready=1, valid=0,
//   prodt=0, all internal registers=0; any in-flight operation is discarded.
//  States: IDLE -> CALC (on accept) -> SIGN -> DONE; DONE -> CALC on accept, else hold.
//  Accept at edge T: latch magnitudes |mlier|,|mcand| (if sgn) or raw values, latch
//   neg = sgn & (mlier[W-1]^mcand[W-1]); clear accumulator; valid falls at T.
//  CALC: N = WIDTH/BPC cycles (edges T+1..T+N); each edge adds mcand_sh*mlier_sh[BPC-1:0]
//   to the 2W-bit accumulator, shifts mcand_sh left BPC and mlier_sh right BPC.
//  SIGN: edge T+N+1 writes prodt = neg ? -acc : acc (mod 2^(2W)); state -> DONE.
//   A zero accumulator is never negated (prodt=0, never all-ones artefacts).
//  Latency: valid=1 from edge T+N+1. W=32: BPC=1 -> 33 cycles, BPC=2 -> 17.
//  prodt and valid hold in DONE indefinitely until next accept or reset.
//  start while ready=0 (CALC/SIGN) is ignored; no queuing. Operand changes after
//   accept have no effect.
//  Most negative operand: |-2^(W-1)| = 2^(W-1) fits W-bit unsigned magnitude;
//   (-2^(W-1))*(-2^(W-1)) = 2^(2W-2), representable.
//  Unsigned mode: full 2W-bit unsigned product, no sign step effect (neg=0).
//  Back-to-back: start held high in DONE re-accepts every completion edge+1;
//   valid is high exactly one cycle per result in that case.
// CONFIGURATION
//  SEQ_MULT_ZERO_SKIP_EN defined: CALC exits to SIGN on the edge where the shifted
//   multiplier register becomes zero (minimum 1 CALC cycle). Latency =
//   1 + max(1, ceil((msb_index(|mlier|)+1)/BPC)); mlier=0 -> 2 cycles.
//   Results identical to non-skip build.
//  Not defined: fixed latency N+1 for every operand; no zero-detect logic.
// TESTING
//  1 W=32,BPC=1,sgn=0: FFFFFFFF*FFFFFFFF -> valid at +33, prodt=FFFFFFFE00000001.
//  2 sgn=1: -1*-1 -> prodt=1; -2^31*-2^31 -> 4000000000000000; -3*5 -> FFFFFFFFFFFFFFF1;
//    0*-7 -> 0 (no negation artefact).
//  3 BPC=2 rerun of 1 and 2 -> same products, valid at +17; ready=0 for 16+1 cycles.
//  4 start pulsed mid-CALC with new operands -> ignored, first result unchanged;
//    start held high -> back-to-back results, valid one cycle each.
//  5 reset_n low at CALC cycle 10 -> same cycle ready=1,valid=0,prodt=0; next op correct.
//  6 SEQ_MULT_ZERO_SKIP_EN, BPC=1: mlier=3,mcand=7 -> prodt=21 at +3; mlier=0 -> 0 at +2;
//    random 10k signed/unsigned vs reference model, both builds, all params.

Source files
------------

// File: rtl/seq_mult_param.sv
// Parametrised shift/add sequential multiplier (radix 2^BPC), signed/unsigned, ready/valid.
// Optional build macro SEQ_MULT_ZERO_SKIP_EN: leave CALC early once the remaining multiplier bits are zero.
module seq_mult_param #(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   mlier,
  input  logic [WIDTH-1:0]   mcand,
  output logic               ready,
  output logic               valid,
  output logic [2*WIDTH-1:0] prodt
);
  localparam int N = WIDTH / BPC;

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t               state_q;
  logic [WIDTH-1:0]     mlier_q;
  logic [2*WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [2*WIDTH-1:0]   prodt_q;
  logic                 neg_q;
  logic                 ready_q;
  logic                 valid_q;
`ifndef SEQ_MULT_ZERO_SKIP_EN
  localparam int CW = (N > 2) ? $clog2(N) : 1;
  logic [CW-1:0]        cnt_q;
`endif

  logic [WIDTH-1:0]            mag_lier, mag_cand;
  logic [BPC-1:0][2*WIDTH-1:0] pp;
  logic [2*WIDTH-1:0]          pp_sum, acc_d, mcand_d;
  logic [WIDTH-1:0]            mlier_d;

  // The most negative operand negates to itself, which is its correct unsigned magnitude.
  assign mag_lier = (sgn && mlier[WIDTH-1]) ? -mlier : mlier;
  assign mag_cand = (sgn && mcand[WIDTH-1]) ? -mcand : mcand;

  for (genvar b = 0; b < BPC; b++) begin : g_pp
    assign pp[b] = mlier_q[b] ? (mcand_q << b) : '0;
  end

  always_comb begin
    pp_sum = '0;
    for (int b = 0; b < BPC; b++) pp_sum = pp_sum + pp[b];
    acc_d   = acc_q + pp_sum;
    mlier_d = mlier_q >> BPC;
    mcand_d = mcand_q << BPC;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      mlier_q <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      prodt_q <= '0;
      neg_q   <= 1'b0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
`ifndef SEQ_MULT_ZERO_SKIP_EN
      cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            mlier_q <= mag_lier;
            mcand_q <= {{WIDTH{1'b0}}, mag_cand};
            neg_q   <= sgn & (mlier[WIDTH-1] ^ mcand[WIDTH-1]);
            acc_q   <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            state_q <= CALC;
`ifndef SEQ_MULT_ZERO_SKIP_EN
            cnt_q   <= CW'(N - 1);
`endif
          end
        end
        CALC: begin
          acc_q   <= acc_d;
          mlier_q <= mlier_d;
          mcand_q <= mcand_d;
`ifdef SEQ_MULT_ZERO_SKIP_EN
          if (mlier_d == '0) state_q <= SIGN;
`else
          if (cnt_q == '0) state_q <= SIGN;
          else             cnt_q   <= cnt_q - 1'b1;
`endif
        end
        SIGN: begin
          prodt_q <= (neg_q && acc_q != '0) ? -acc_q : acc_q;
          ready_q <= 1'b1;
          valid_q <= 1'b1;
          state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready = ready_q;
  assign valid = valid_q;
  assign prodt = prodt_q;
endmodule

// File: tb/tb_seq_mult_param.sv
// Scoreboard bench for seq_mult_param: arithmetic reference model, randomized and directed ops.
module tb_seq_mult_param;
  localparam int W = 32;
  localparam int BPC = 1;
  localparam int N = W / BPC;

  logic           clock, reset_n, start, sgn, ready, valid;
  logic [W-1:0]   mlier, mcand;
  logic [2*W-1:0] prodt;

  seq_mult_param #(.WIDTH(W), .BPC(BPC)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .sgn(sgn),
    .mlier(mlier), .mcand(mcand), .ready(ready), .valid(valid), .prodt(prodt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic [2*W-1:0] p;
    int             lat;
    int             acc;
  } exp_t;

  exp_t           q[$];
  int             checks = 0, failures = 0;
  int             cyc = 0, ready_at = 0, ops = 0;
  logic           vprev = 1'b0;
  logic [2*W-1:0] last_p = '0;
  logic           mdl_ready;

  assign mdl_ready = reset_n && (cyc >= ready_at);

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d act=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_prod(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] ea, eb;
    ea = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return ea * eb;
  endfunction

  function automatic int ref_lat(input logic s, input logic [W-1:0] a);
`ifdef SEQ_MULT_ZERO_SKIP_EN
    logic [W-1:0] m;
    int bits, c;
    m = (s && a[W-1]) ? -a : a;
    bits = 0;
    for (int i = 0; i < W; i++) if (m[i]) bits = i + 1;
    c = (bits + BPC - 1) / BPC;
    if (c < 1) c = 1;
    return 1 + c;
`else
    return N + 1 + 0 * int'(s) + 0 * int'(a[0]);
`endif
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[W-1:0];
  endfunction

  // Accept model: the bench decides from its own timing model when a request is taken.
  always @(negedge clock) begin
    exp_t e;
    if (!reset_n) begin
      q.delete();
      ops = 0;
      ready_at = 0;
    end else begin
      chk("ready", {{(2*W-1){1'b0}}, ready}, {{(2*W-1){1'b0}}, mdl_ready});
      chk("valid", {{(2*W-1){1'b0}}, valid}, {{(2*W-1){1'b0}}, (ops > 0) && mdl_ready});
      if (start && mdl_ready) begin
        e.p   = ref_prod(sgn, mlier, mcand);
        e.lat = ref_lat(sgn, mlier);
        e.acc = cyc + 1;
        q.push_back(e);
        ready_at = cyc + 1 + e.lat;
        ops++;
      end
    end
  end

  always @(negedge clock) begin
    exp_t e;
    if (!reset_n) vprev = 1'b0;
    else begin
      if (valid && !vprev) begin
        if (q.size() == 0) chk("unexpected_result", prodt, ~prodt);
        else begin
          e = q.pop_front();
          chk("prodt", prodt, e.p);
          chk("latency", 2*W'(cyc - e.acc), 2*W'(e.lat));
          last_p = e.p;
        end
      end else if (valid) chk("prodt_hold", prodt, last_p);
      vprev = valid;
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!mdl_ready && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    if (!mdl_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    wait_ready();
    sgn = s; mlier = a; mcand = b; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    mlier = rnd(); mcand = rnd(); sgn = $urandom_range(0, 1);
  endtask

  logic [W-1:0] da[9], db[9];
  bit           ds[9];
  logic [W-1:0] sp[6];

  initial begin
    int n;
    reset_n = 1'b0; start = 1'b0; sgn = 1'b0; mlier = '0; mcand = '0;
    da[0] = '1;              db[0] = '1;              ds[0] = 0;
    da[1] = '1;              db[1] = '1;              ds[1] = 1;
    da[2] = {1'b1, {(W-1){1'b0}}}; db[2] = {1'b1, {(W-1){1'b0}}}; ds[2] = 1;
    da[3] = W'(-3);          db[3] = W'(5);           ds[3] = 1;
    da[4] = '0;              db[4] = W'(-7);          ds[4] = 1;
    da[5] = W'(3);           db[5] = W'(7);           ds[5] = 0;
    da[6] = '0;              db[6] = W'(12345);       ds[6] = 0;
    da[7] = W'(-7);          db[7] = '0;              ds[7] = 1;
    da[8] = {1'b1, {(W-1){1'b0}}}; db[8] = W'(1);     ds[8] = 1;
    sp[0] = '0; sp[1] = W'(1); sp[2] = '1; sp[3] = {1'b1, {(W-1){1'b0}}};
    sp[4] = {1'b0, {(W-1){1'b1}}}; sp[5] = W'(3);

    repeat (3) @(posedge clock);
    #1;
    chk("reset_prodt", prodt, '0);
    chk("reset_ready", {{(2*W-1){1'b0}}, ready}, {{(2*W-1){1'b0}}, 1'b1});
    chk("reset_valid", {{(2*W-1){1'b0}}, valid}, '0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 9; i++) op(ds[i], da[i], db[i]);

    // A start while busy must be dropped; the model never accepts it.
    op(1'b0, {1'b1, rnd() >> 1}, rnd());
    repeat (3) @(posedge clock);
    #1; start = 1'b1; mlier = rnd(); mcand = rnd();
    @(posedge clock); #1; start = 1'b0;

    wait_ready();
    start = 1'b1;
    repeat (6 * (N + 1)) begin
      @(posedge clock); #1;
      mlier = rnd(); mcand = rnd(); sgn = $urandom_range(0, 1);
    end
    start = 1'b0;

    // Asynchronous reset in the middle of CALC discards the operation.
    op(1'b0, {1'b1, rnd() >> 1}, rnd());
    repeat (9) @(posedge clock);
    #1; reset_n = 1'b0;
    #1;
    chk("midreset_ready", {{(2*W-1){1'b0}}, ready}, {{(2*W-1){1'b0}}, 1'b1});
    chk("midreset_valid", {{(2*W-1){1'b0}}, valid}, '0);
    chk("midreset_prodt", prodt, '0);
    @(posedge clock); #1; reset_n = 1'b1;
    op(1'b1, W'(-3), W'(5));

    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 5)] : rnd();
      b = ($urandom_range(0, 3) == 0) ? sp[$urandom_range(0, 5)] : rnd();
      if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, W - 1);
      op($urandom_range(0, 1), a, b);
      repeat ($urandom_range(0, 3)) @(posedge clock);
      #1;
    end

    n = 0;
    while ((q.size() != 0 || !mdl_ready) && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    repeat (2) @(posedge clock);
    #1;
    chk("drain", 2*W'(q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
